// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce, rotate, bar fill and blink patterns stepped by a prescaled clock.
// Optional global PWM dimming (BRIGHT port) is compiled in when LED_PATTERN_PWM_EN is defined.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned STEP_HZ    = 10,
  parameter int unsigned NUM_LEDS   = 6,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned PWM_BITS   = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                MODE_NEXT,
  input  logic [1:0]          SPEED,
`ifdef LED_PATTERN_PWM_EN
  input  logic [PWM_BITS-1:0] BRIGHT,
`endif
  output logic [NUM_LEDS-1:0] LEDS,
  output logic [1:0]          MODE,
  output logic                STEP
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int unsigned         DIV     = CLK_HZ / STEP_HZ;
  localparam logic [NUM_LEDS-1:0] PAT_ONE = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] PAT_ALL = '1;

  if (DIV < 8) begin : gBadDiv
    $error("led_pattern_gen: CLK_HZ/STEP_HZ must be at least 8");
  end
  if (NUM_LEDS < 2) begin : gBadLeds
    $error("led_pattern_gen: NUM_LEDS must be at least 2");
  end
  if (PWM_BITS < 1) begin : gBadPwm
    $error("led_pattern_gen: PWM_BITS must be at least 1");
  end

  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                dirUp_q, dirUp_d;
  logic [31:0]         count_q, count_d;
  logic                stepPend_q, stepPend_d;
  logic                step_q, step_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  logic [31:0]         pmax;
  logic                tick;
  logic [NUM_LEDS-1:0] patAdv;
  logic                dirAdv;
  logic [NUM_LEDS-1:0] g;

  // Prescaler compare uses >= so a mid-period drop to a faster speed wraps on the next edge.
  always_comb begin
    pmax = (32'(DIV) >> SPEED) - 32'd1;
    tick = (SPEED != 2'd3) && (count_q >= pmax);
  end

  // Pattern advance for the current mode; the bounce reverses and moves in the same step.
  always_comb begin
    patAdv = pat_q;
    dirAdv = dirUp_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (dirUp_q) begin
          if (pat_q[NUM_LEDS-1]) begin
            patAdv = pat_q >> 1;
            dirAdv = 1'b0;
          end else begin
            patAdv = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            patAdv = pat_q << 1;
            dirAdv = 1'b1;
          end else begin
            patAdv = pat_q >> 1;
          end
        end
      end
      MODE_ROTATE: patAdv = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
      MODE_BAR: begin
        // Bit 0 is set throughout the fill phase and clear throughout the empty phase.
        if (pat_q == '0) begin
          patAdv = PAT_ONE;
        end else if (&pat_q) begin
          patAdv = pat_q << 1;
        end else begin
          patAdv = {pat_q[NUM_LEDS-2:0], pat_q[0]};
        end
      end
      MODE_BLINK: patAdv = (&pat_q) ? '0 : PAT_ALL;
      default: patAdv = pat_q;
    endcase
  end

  // A mode change takes priority over a coincident tick and never raises STEP.
  always_comb begin
    mode_d     = mode_q;
    pat_d      = pat_q;
    dirUp_d    = dirUp_q;
    count_d    = count_q;
    stepPend_d = 1'b0;
    if (MODE_NEXT) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      pat_d   = (mode_d == MODE_BLINK) ? PAT_ALL : PAT_ONE;
      dirUp_d = 1'b1;
      count_d = '0;
    end else if (SPEED == 2'd3) begin
      count_d = '0;
    end else if (tick) begin
      pat_d      = patAdv;
      dirUp_d    = dirAdv;
      count_d    = '0;
      stepPend_d = 1'b1;
    end else begin
      count_d = count_q + 32'd1;
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_BITS-1:0] pc_q;
  logic                pwmOn;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + 1'b1;
    end
  end

  always_comb begin
    pwmOn = (pc_q < BRIGHT) | (&BRIGHT);
    g     = pat_q & {NUM_LEDS{pwmOn}};
  end
`else
  always_comb begin
    g = pat_q;
  end
`endif

  // STEP is delayed one extra stage so it lines up with the first cycle LEDS shows the new pattern.
  always_comb begin
    step_d = stepPend_q;
    leds_d = ACTIVE_LOW ? ~g : g;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mode_q     <= MODE_BOUNCE;
      pat_q      <= PAT_ONE;
      dirUp_q    <= 1'b1;
      count_q    <= '0;
      stepPend_q <= 1'b0;
      step_q     <= 1'b0;
      leds_q     <= ACTIVE_LOW ? ~PAT_ONE : PAT_ONE;
    end else begin
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      dirUp_q    <= dirUp_d;
      count_q    <= count_d;
      stepPend_q <= stepPend_d;
      step_q     <= step_d;
      leds_q     <= leds_d;
    end
  end

  assign LEDS = leds_q;
  assign MODE = mode_q;
  assign STEP = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen at CLK_HZ=100, STEP_HZ=10, six active-low LEDs.
// The PWM section is included when LED_PATTERN_PWM_EN is defined.
module tb_led_pattern_gen;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       MODE_NEXT = 1'b0;
  logic [1:0] SPEED = 2'd0;
  logic [3:0] BRIGHT = 4'hF;
  logic [5:0] LEDS;
  logic [1:0] MODE;
  logic       STEP;

  int assertCount = 0;
  int failCount = 0;

  logic [5:0] bouncePat [10] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01};
  logic [5:0] rotatePat [6]  = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
  logic [5:0] barPat [12]    = '{6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00, 6'h01};

  led_pattern_gen #(
    .CLK_HZ(100),
    .STEP_HZ(10),
    .NUM_LEDS(6),
    .ACTIVE_LOW(1'b1),
    .PWM_BITS(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .MODE_NEXT(MODE_NEXT),
    .SPEED(SPEED),
`ifdef LED_PATTERN_PWM_EN
    .BRIGHT(BRIGHT),
`endif
    .LEDS(LEDS),
    .MODE(MODE),
    .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] ledsFor(input logic [5:0] p);
    return ~p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One mode-change pulse with SPEED applied alongside; returns just after the pulse edge.
  task automatic applyStimulus(input logic [1:0] speed);
    SPEED = speed;
    MODE_NEXT = 1'b1;
    stepClock(1);
    MODE_NEXT = 1'b0;
  endtask

  task automatic waitStep(input int budget, output int cycles);
    cycles = 0;
    do begin
      stepClock(1);
      cycles++;
    end while (STEP !== 1'b1 && cycles < budget);
  endtask

  task automatic checkStep(input string tag, input int expCycles, input logic [5:0] expPat);
    int c;
    waitStep(expCycles + 5, c);
    checkOutput({tag, "Period"}, c, expCycles);
    checkOutput({tag, "Leds"}, LEDS, ledsFor(expPat));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stepsSeen;
    int hits;

    #12;
    checkOutput("resetLeds", LEDS, 6'b111110);
    checkOutput("resetMode", MODE, 2'd0);
    checkOutput("resetStep", STEP, 1'b0);
    stepClock(1);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      checkStep($sformatf("bounce%0d", i), (i == 0) ? 11 : 10, bouncePat[i]);
    end

    applyStimulus(2'd0);
    checkOutput("rotateMode", MODE, 2'd1);
    checkOutput("rotateNoStep", STEP, 1'b0);
    stepClock(1);
    checkOutput("rotateStart", LEDS, ledsFor(6'h01));
    checkOutput("rotateNoStep2", STEP, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkStep($sformatf("rotate%0d", i), 10, rotatePat[i]);
    end

    applyStimulus(2'd0);
    checkOutput("barMode", MODE, 2'd2);
    stepClock(1);
    checkOutput("barStart", LEDS, ledsFor(6'h01));
    for (int i = 0; i < 12; i++) begin
      checkStep($sformatf("bar%0d", i), 10, barPat[i]);
    end

    applyStimulus(2'd0);
    checkOutput("blinkMode", MODE, 2'd3);
    stepClock(1);
    checkOutput("blinkStart", LEDS, ledsFor(6'h3F));
    checkStep("blink0", 10, 6'h00);
    checkStep("blink1", 10, 6'h3F);

    applyStimulus(2'd1);
    checkOutput("speed1Mode", MODE, 2'd0);
    stepClock(1);
    checkStep("speed1a", 5, 6'h02);
    checkStep("speed1b", 5, 6'h04);

    applyStimulus(2'd2);
    checkOutput("speed2Mode", MODE, 2'd1);
    stepClock(1);
    checkStep("speed2a", 2, 6'h02);
    checkStep("speed2b", 2, 6'h04);

    // Leave count at 7 with SPEED=0, then switch to SPEED=2.
    applyStimulus(2'd0);
    checkOutput("midMode", MODE, 2'd2);
    stepClock(1);
    checkOutput("midStart", LEDS, ledsFor(6'h01));
    stepClock(6);
    SPEED = 2'd2;
    checkStep("midSwitch", 2, 6'h03);

    SPEED = 2'd3;
    stepsSeen = 0;
    for (int i = 0; i < 100; i++) begin
      stepClock(1);
      if (STEP === 1'b1) stepsSeen++;
    end
    checkOutput("freezeSteps", stepsSeen, 0);
    checkOutput("freezeLeds", LEDS, ledsFor(6'h03));

    // Mode change lands on the same edge as a tick.
    applyStimulus(2'd0);
    checkOutput("collideSetup", MODE, 2'd3);
    stepClock(9);
    applyStimulus(2'd0);
    checkOutput("collideMode", MODE, 2'd0);
    checkOutput("collideNoStep", STEP, 1'b0);
    stepClock(1);
    checkOutput("collideNoStep2", STEP, 1'b0);
    checkOutput("collideStart", LEDS, ledsFor(6'h01));
    checkStep("collideNext", 10, 6'h02);

    SPEED = 2'd0;
    MODE_NEXT = 1'b1;
    stepClock(2);
    MODE_NEXT = 1'b0;
    checkOutput("holdTwoMode", MODE, 2'd2);
    stepClock(1);
    checkStep("holdTwoStep", 10, 6'h03);
    stepClock(4);
    nRST = 1'b0;
    #1;
    checkOutput("asyncResetLeds", LEDS, 6'b111110);
    checkOutput("asyncResetMode", MODE, 2'd0);
    checkOutput("asyncResetStep", STEP, 1'b0);
    stepClock(1);
    nRST = 1'b1;
    checkStep("afterReset", 11, 6'h02);

`ifdef LED_PATTERN_PWM_EN
    SPEED = 2'd3;
    BRIGHT = 4'd4;
    stepClock(2);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      stepClock(1);
      if (LEDS[1] == 1'b0) hits++;
    end
    checkOutput("pwmBright4", hits, 4);

    BRIGHT = 4'd0;
    stepClock(2);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      stepClock(1);
      if (LEDS == 6'h3F) hits++;
    end
    checkOutput("pwmBright0", hits, 16);

    BRIGHT = 4'd15;
    stepClock(2);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      stepClock(1);
      if (LEDS == ledsFor(6'h02)) hits++;
    end
    checkOutput("pwmBright15", hits, 16);
`else
    hits = 0;
    stepsSeen = hits;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for the board-level demo and status designs. It drives an `NUM_LEDS`-wide LED bank with one of four step patterns: bounce, rotate, bar fill and blink. The step rate comes from a prescaled system clock and can be selected at run time. A single-cycle pulse input cycles through the patterns. The block sits directly between the clock/reset tree and the LED pins, with optional global PWM dimming.

## Interface
- `CLK_HZ`, 27000000, system clock frequency in Hz.
- `STEP_HZ`, 10, base pattern step rate in Hz. `CLK_HZ/STEP_HZ` must be ≥ 8.
- `NUM_LEDS`, 6, LED count. Must be ≥ 2.
- `ACTIVE_LOW`, 1, selects LED polarity: 1 inverts `LEDS`, 0 drives them true.
- `PWM_BITS`, 4, brightness resolution. Used only with `LED_PATTERN_PWM_EN`.
- `CLK` input 1 system clock.
- `nRST` input 1 reset, asynchronous, active-low; clock CLK.
- `MODE_NEXT` input 1 single-cycle pulse, synchronous to `CLK`; advances the mode.
- `SPEED` input 2 step-rate select.
- `BRIGHT` input `PWM_BITS` brightness level. Present only with `LED_PATTERN_PWM_EN`.
- `LEDS` output `NUM_LEDS` LED drive, registered.
- `MODE` output 2 current mode: 0 bounce, 1 rotate, 2 bar, 3 blink.
- `STEP` output 1 one-cycle pulse, asserted the cycle after each pattern advance.

## Operation
- **Prescaler:** 32-bit `count`; `PMAX = (CLK_HZ/STEP_HZ) >> SPEED − 1` for `SPEED` 0–2.
  - `SPEED`=3 freezes the pattern: `count` holds at 0 and no steps occur.
  - A tick occurs on the edge where `count >= PMAX`. On that edge `count` returns to 0.
  - `>=` is used so that a `SPEED` change mid-period wraps on the next edge.
- **Tick:** the internal pattern register `pat` advances on the tick edge, and `STEP` is 1 for the following cycle.
- **Bounce (mode 0):**
  - One-hot position p with a direction bit.
  - Reversal and move happen in the same step: p goes 0,1,…,N−1,N−2,…,1,0,1,… (period 2N−2 steps, no duplicated end position).
- **Rotate (mode 1):** one-hot shift left; bit N−1 wraps to bit 0 (period N).
- **Bar (mode 2):**
  - Fill phase: shift left inserting 1, 0…01 → 1…11.
  - Empty phase: shift left inserting 0, 1…10 → 0…00.
  - After 0…00 the pattern returns to 0…01 (period 2N).
- **Blink (mode 3):** `pat` alternates all-ones / all-zeros, starting all-ones.
- **Mode change:** `MODE_NEXT`=1 does the following:
  - `MODE` ← `MODE`+1 mod 4.
  - `pat` ← start pattern of the new mode: 0…01 with direction up, except blink which starts all-ones.
  - `count` ← 0.
  - `STEP` is not pulsed.
- **Simultaneous `MODE_NEXT` and tick:** the mode change wins and there is no pattern advance.
- **Output:** `LEDS` ← `ACTIVE_LOW ? ~g : g` each cycle, where `g = pat` (gated by PWM when enabled).
- **Reset (asynchronous, any time including mid-step):**
  - `MODE`=0, `pat`=0…01, direction up, `count`=0, `STEP`=0.
  - `LEDS` = `ACTIVE_LOW ? ~0…01 : 0…01`.
  - PWM counter=0.

## Timing
- Step period is `(PMAX+1)` clocks. Example: CLK_HZ=100, STEP_HZ=10, SPEED=0 gives 10 clocks; SPEED=1 gives 5; SPEED=2 gives 2.
- `LEDS` lags `pat` by 1 clock. `STEP` is aligned with the first cycle in which the new `pat` is visible in `LEDS`.
- `MODE_NEXT` → `MODE` updates 1 clock later and `LEDS` shows the start pattern 2 clocks later. The first step follows `PMAX+1` clocks after the mode change.
- `MODE_NEXT` held high for k cycles advances the mode k times. This is legal, and the caller is responsible for debouncing.

## Configuration
- **`LED_PATTERN_PWM_EN` defined:**
  - Adds the `BRIGHT` port and a free-running `PWM_BITS` counter `pc`.
  - `g = pat & {N{(pc < BRIGHT) | (&BRIGHT)}}`.
  - `BRIGHT`=0 gives all LEDs off. All-ones gives fully on. Otherwise the duty is `BRIGHT/2^PWM_BITS`.
- **Not defined:** no `BRIGHT` port, no PWM counter, `g = pat`. `LEDS` changes only on steps, mode changes and reset.

## Test plan
- Use CLK_HZ=100, STEP_HZ=10, NUM_LEDS=6, ACTIVE_LOW=1 throughout.
- **Reset, bounce:** release reset → `LEDS`=6'b111110, `MODE`=0. Over 10 steps `pat` reads 01,02,04,08,10,20,10,08,04,02 hex, then 01. `STEP` pulses every 10 clocks.
- **Rotate:** one `MODE_NEXT` pulse → `MODE`=1, `pat` 01→02→…→20→01. `STEP` is never asserted on the mode-change cycle.
- **Bar, then blink:** `MODE`=2 → `pat` 01,03,07,0F,1F,3F,3E,3C,38,30,20,00,01. Next pulse → `MODE`=3, `pat` 3F,00,3F.
- **Speed:**
  - `SPEED`=1 → period 5 clocks; `SPEED`=2 → 2 clocks.
  - Switch from 0 to 2 at count=7 → tick on the next edge.
  - `SPEED`=3 → `pat` frozen for 100 clocks.
- **Collisions:**
  - `MODE_NEXT` on a tick edge → no advance, start pattern shown, next step 10 clocks later.
  - `nRST` low mid-period in mode 2 → immediate `LEDS`=111110, `MODE`=0.
- **PWM (`LED_PATTERN_PWM_EN`, PWM_BITS=4):**
  - `BRIGHT`=4 → lit LED low 4 of every 16 clocks.
  - `BRIGHT`=0 → `LEDS`=111111.
  - `BRIGHT`=15 → constantly lit.
